// File: rtl/fx2qspi_pkg.sv
// Shared definitions for the FX2-to-QSPI bridge: header layout, mode/direction
// codes and the transfer sequencer state encoding.
package fx2qspi_pkg;

  localparam logic [1:0] MODE_SPI   = 2'b00;
  localparam logic [1:0] MODE_DPI   = 2'b01;
  localparam logic [1:0] MODE_QPI   = 2'b10;
  localparam logic [1:0] MODE_FLUSH = 2'b11;

  localparam logic DIR_OUT = 1'b0;
  localparam logic DIR_IN  = 1'b1;

  localparam int HDR_CS       = 7;
  localparam int HDR_MODE_MSB = 6;
  localparam int HDR_MODE_LSB = 5;
  localparam int HDR_DIR      = 4;
  localparam int HDR_LEN_MSB  = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_H1,
    ST_DECODE,
    ST_OUT_RUN,
    ST_IN_RUN,
    ST_FLUSH
  } xfer_state_e;

  // Extracts the two-bit mode field from a header byte0.
  function automatic logic [1:0] hdr_mode(input logic [7:0] b);
    return b[HDR_MODE_MSB:HDR_MODE_LSB];
  endfunction

endpackage

// File: rtl/qspi_xfer_sequencer.sv
// Command sequencer between the FX2 OUT-FIFO reader, the QSPI byte engine and
// the FX2 IN-FIFO writer. Parses the two-byte header, owns CS/mode/direction,
// issues one engine request per data byte and returns IN bytes with packet-end.
module qspi_xfer_sequencer
  import fx2qspi_pkg::*;
#(
  parameter int LEN_W          = 12,
  parameter bit PKTEND_ON_LAST = 1'b1
) (
  input  logic       FX_IFCLK,
  input  logic       FX_RST,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       tx_last,
  input  logic       tx_ready,
  output logic       tx_flush,
  output logic       spi_cs,
  output logic [1:0] spi_mode,
  output logic       spi_dir,
  output logic       eng_start,
  output logic [7:0] eng_wdata,
  input  logic       eng_busy,
  input  logic       eng_done,
  input  logic [7:0] eng_rdata,
  output logic       busy
);

  localparam logic [LEN_W-1:0] CNT_ONE = LEN_W'(1);

  xfer_state_e      state, state_next;
  logic [1:0]       hdr_mode_q;
  logic             hdr_dir_q;
  logic [3:0]       len_hi_q;
  logic [7:0]       len_lo_q;
  logic [LEN_W-1:0] count_q;
  logic             cs_q;
  logic [1:0]       mode_q;
  logic             dir_q;
  logic [7:0]       hold_q;
  logic             hold_full_q;
  logic [7:0]       wdata_q;
  logic             start_q;
  logic             inflight_q;
  logic             last_pend_q;
  logic [7:0]       tx_data_q;
  logic             tx_valid_q;
  logic             tx_last_q;
  logic             tx_flush_q;

  logic             issue;
  logic             rx_accept;
  logic             tx_take;
  logic             done_ok;
  logic             count_zero;
  logic             eng_free_in;
  logic             eng_free_out;
  logic [LEN_W-1:0] hdr_len;

  assign hdr_len      = LEN_W'({len_hi_q, len_lo_q});
  assign count_zero   = (count_q == '0);
  assign done_ok      = eng_done && inflight_q;
  assign eng_free_in  = !inflight_q && !start_q && !eng_busy;
  assign eng_free_out = (!inflight_q || eng_done) && !start_q && !eng_busy;
  assign rx_accept    = rx_valid && rx_ready;
  assign tx_take      = tx_valid_q && tx_ready;

  // State register; reset aborts any command in progress.
  always_ff @(posedge FX_IFCLK or posedge FX_RST) begin
    if (FX_RST) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state, rx flow control and engine-request decision.
  always_comb begin
    state_next = state;
    rx_ready   = 1'b0;
    issue      = 1'b0;
    case (state)
      ST_IDLE: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          if (hdr_mode(rx_data) == MODE_FLUSH) state_next = ST_FLUSH;
          else if (!rx_data[HDR_CS])           state_next = ST_IDLE;
          else                                 state_next = ST_H1;
        end
      end
      ST_H1: begin
        rx_ready = 1'b1;
        if (rx_valid) state_next = ST_DECODE;
      end
      ST_DECODE: begin
        if (!eng_busy) begin
          if (hdr_len == '0)           state_next = ST_IDLE;
          else if (hdr_dir_q == DIR_IN) state_next = ST_IN_RUN;
          else                          state_next = ST_OUT_RUN;
        end
      end
      ST_OUT_RUN: begin
        rx_ready = !hold_full_q && !count_zero;
        issue    = hold_full_q && eng_free_out;
        if (count_zero && !hold_full_q && eng_free_in) state_next = ST_IDLE;
      end
      ST_IN_RUN: begin
        issue = !count_zero && eng_free_in && (!tx_valid_q || tx_ready);
        if (count_zero && eng_free_in && !tx_valid_q) state_next = ST_IDLE;
      end
      ST_FLUSH: begin
        if (!tx_valid_q && !eng_busy) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    if (FX_RST) begin
      rx_ready = 1'b0;
      issue    = 1'b0;
    end
  end

  // Header capture, link registers, byte counter, holding and tx registers.
  always_ff @(posedge FX_IFCLK or posedge FX_RST) begin
    if (FX_RST) begin
      hdr_mode_q  <= '0;
      hdr_dir_q   <= 1'b0;
      len_hi_q    <= '0;
      len_lo_q    <= '0;
      count_q     <= '0;
      cs_q        <= 1'b0;
      mode_q      <= '0;
      dir_q       <= 1'b0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      wdata_q     <= '0;
      start_q     <= 1'b0;
      inflight_q  <= 1'b0;
      last_pend_q <= 1'b0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      tx_last_q   <= 1'b0;
      tx_flush_q  <= 1'b0;
    end else begin
      start_q    <= issue;
      tx_flush_q <= (state == ST_FLUSH) && (state_next == ST_IDLE);

      if (state == ST_IDLE && rx_accept) begin
        hdr_mode_q <= hdr_mode(rx_data);
        hdr_dir_q  <= rx_data[HDR_DIR];
        len_hi_q   <= rx_data[HDR_LEN_MSB:0];
        if (hdr_mode(rx_data) != MODE_FLUSH && !rx_data[HDR_CS]) cs_q <= 1'b0;
      end

      if (state == ST_H1 && rx_accept) len_lo_q <= rx_data;

      if (state == ST_DECODE && !eng_busy) begin
        cs_q    <= 1'b1;
        mode_q  <= hdr_mode_q;
        dir_q   <= hdr_dir_q;
        count_q <= hdr_len;
      end

      if (state == ST_OUT_RUN && rx_accept) begin
        hold_q      <= rx_data;
        hold_full_q <= 1'b1;
      end

      if (issue) begin
        count_q     <= count_q - CNT_ONE;
        last_pend_q <= (count_q == CNT_ONE);
        if (state == ST_OUT_RUN) begin
          wdata_q     <= hold_q;
          hold_full_q <= 1'b0;
        end
      end

      if (issue)        inflight_q <= 1'b1;
      else if (done_ok) inflight_q <= 1'b0;

      if (tx_take) begin
        tx_valid_q <= 1'b0;
        tx_last_q  <= 1'b0;
      end
      if (done_ok && state == ST_IN_RUN) begin
        tx_data_q  <= eng_rdata;
        tx_valid_q <= 1'b1;
        tx_last_q  <= PKTEND_ON_LAST && last_pend_q;
      end
    end
  end

  // A request with an empty counter or an eng_done with nothing in flight is a protocol error.
  assert property (@(posedge FX_IFCLK) disable iff (FX_RST) issue |-> !count_zero);
  assert property (@(posedge FX_IFCLK) disable iff (FX_RST) eng_done |-> inflight_q);

  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign tx_last   = tx_last_q;
  assign tx_flush  = tx_flush_q;
  assign spi_cs    = cs_q;
  assign spi_mode  = mode_q;
  assign spi_dir   = dir_q;
  assign eng_start = start_q;
  assign eng_wdata = wdata_q;
  assign busy      = (state != ST_IDLE);

endmodule
